paddle_ai: RTL

//  Computer-controlled paddle: consumes the ball position produced by the ball block and

---
 rtl/paddle_ai.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/paddle_ai.sv
// Computer-controlled paddle: watches ball_x history to detect approach, waits a reaction delay,
// then tracks ball_y at bounded speed. Optional manual override via `define PADDLE_AI_MANUAL_EN.
module paddle_ai #(
    parameter int SIDE        = 0,
    parameter int MIN_POS     = 0,
    parameter int MAX_POS     = 320,
    parameter int PADDLE_LEN  = 32,
    parameter int BALL_SIZE   = 4,
    parameter int SPEED       = 2,
    parameter int REACT_TICKS = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       move_tick_i,
    input  logic [7:0] ball_x_i,
    input  logic [8:0] ball_y_i,
`ifdef PADDLE_AI_MANUAL_EN
    input  logic       manual_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
`endif
    output logic [8:0] paddle_pos_o,
    output logic       tracking_o
);

    localparam int CENTRE = MIN_POS + (MAX_POS - MIN_POS - PADDLE_LEN) / 2;
    localparam int TOP    = MAX_POS - PADDLE_LEN;

    localparam logic signed [10:0] LO_S     = 11'(MIN_POS);
    localparam logic signed [10:0] HI_S     = 11'(TOP);
    localparam logic signed [10:0] SPEED_S  = 11'(SPEED);
    localparam logic signed [10:0] CENTRE_S = 11'(CENTRE);
    localparam logic signed [10:0] OFFSET_S = 11'(BALL_SIZE / 2 - PADDLE_LEN / 2);
    localparam logic [8:0]         CENTRE_U = 9'(CENTRE);
    localparam logic [7:0]         REACT_C  = 8'(REACT_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECENTRE,
        ST_WAIT,
        ST_TRACK
    } state_t;

    state_t     state_q;
    logic [8:0] paddle_q;
    logic [7:0] prev_x_q;
    logic [7:0] cnt_q;
    logic       tracking_q;

    logic                approach;
    logic                recede;
    logic signed [10:0]  target_s;
    logic [8:0]          centre_step;
    logic [8:0]          track_step;

    function automatic logic signed [10:0] clamp_pos(input logic signed [10:0] v);
        if (v < LO_S) return LO_S;
        if (v > HI_S) return HI_S;
        return v;
    endfunction

    // Move at most SPEED toward tgt, landing exactly on it when close enough.
    function automatic logic [8:0] step_to(input logic [8:0] pos, input logic signed [10:0] tgt);
        logic signed [10:0] p;
        logic signed [10:0] d;
        logic signed [10:0] r;
        p = signed'({2'b00, pos});
        d = tgt - p;
        if (d > SPEED_S)       r = p + SPEED_S;
        else if (d < -SPEED_S) r = p - SPEED_S;
        else                   r = tgt;
        r = clamp_pos(r);
        return r[8:0];
    endfunction

    always_comb begin
        approach    = (SIDE != 0) ? (ball_x_i > prev_x_q) : (ball_x_i < prev_x_q);
        recede      = (SIDE != 0) ? (ball_x_i < prev_x_q) : (ball_x_i > prev_x_q);
        target_s    = clamp_pos(signed'({2'b00, ball_y_i}) + OFFSET_S);
        centre_step = step_to(paddle_q, CENTRE_S);
        track_step  = step_to(paddle_q, target_s);
    end

`ifdef PADDLE_AI_MANUAL_EN
    logic [8:0] manual_step;

    always_comb begin
        logic signed [10:0] p;
        logic signed [10:0] r;
        p = signed'({2'b00, paddle_q});
        r = p;
        if (btn_up_i && !btn_down_i)      r = p - SPEED_S;
        else if (btn_down_i && !btn_up_i) r = p + SPEED_S;
        r = clamp_pos(r);
        manual_step = r[8:0];
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            paddle_q   <= CENTRE_U;
            prev_x_q   <= 8'd0;
            cnt_q      <= 8'd0;
            tracking_q <= 1'b0;
        end else if (move_tick_i) begin
            prev_x_q <= ball_x_i;
`ifdef PADDLE_AI_MANUAL_EN
            if (manual_i) begin
                state_q    <= ST_RECENTRE;
                tracking_q <= 1'b0;
                paddle_q   <= manual_step;
            end else begin
`else
            begin
`endif
                case (state_q)
                    ST_IDLE: state_q <= ST_RECENTRE;
                    ST_RECENTRE: begin
                        paddle_q <= centre_step;
                        if (approach) begin
                            if (REACT_TICKS == 0) begin
                                state_q    <= ST_TRACK;
                                tracking_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT;
                                cnt_q   <= REACT_C;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (recede) begin
                            state_q <= ST_RECENTRE;
                            cnt_q   <= 8'd0;
                        end else if (cnt_q <= 8'd1) begin
                            state_q    <= ST_TRACK;
                            tracking_q <= 1'b1;
                            cnt_q      <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    ST_TRACK: begin
                        paddle_q <= track_step;
                        if (recede) begin
                            state_q    <= ST_RECENTRE;
                            tracking_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        tracking_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign paddle_pos_o = paddle_q;
    assign tracking_o   = tracking_q;

endmodule
